// File: rtl/mem_requester_pkg.sv
// Shared types and helpers for the 6502 RAM requester and its address decoders.
package mem_requester_pkg;

  localparam int CPU_AW = 16;

  localparam logic [3:0] WE_ALL  = 4'hF;
  localparam logic [3:0] WE_NONE = 4'h0;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ISSUE,
    RD_WAIT,
    RSP,
    CLEAR
  } state_t;

  // One extra bit keeps addresses below the base from aliasing into the window.
  function automatic logic [CPU_AW:0] window_offset(input logic [CPU_AW-1:0] addr,
                                                    input logic [CPU_AW-1:0] base);
    return {1'b0, addr} - {1'b0, base};
  endfunction

  function automatic logic window_hit(input logic [CPU_AW-1:0] addr,
                                      input logic [CPU_AW-1:0] base,
                                      input int unsigned       aw);
    logic [CPU_AW:0] limit;
    limit = (CPU_AW+1)'(1) << aw;
    return (addr >= base) && (window_offset(addr, base) < limit);
  endfunction

endpackage

// File: rtl/mem_window_decode.sv
// Combinational window decoder: maps a CPU address onto a RAM offset and flags hits.
module mem_window_decode
  import mem_requester_pkg::*;
#(
  parameter int                        CPU_ADDR_WIDTH = 16,
  parameter int                        ADDR_WIDTH     = 12,
  parameter logic [CPU_ADDR_WIDTH-1:0] BASE_ADDR      = 16'h0000
) (
  input  logic [CPU_ADDR_WIDTH-1:0] req_addr,
  output logic                      hit,
  output logic [ADDR_WIDTH-1:0]     mem_off
);

  assign hit     = window_hit(CPU_AW'(req_addr), CPU_AW'(BASE_ADDR), ADDR_WIDTH);
  assign mem_off = ADDR_WIDTH'(window_offset(CPU_AW'(req_addr), CPU_AW'(BASE_ADDR)));

endmodule

// File: rtl/mem_requester.sv
// CPU-side requester for the single-port byte RAM: request handshake, window decode,
// one-cycle read latency handling and a bulk zero-fill engine.
module mem_requester
  import mem_requester_pkg::*;
#(
  parameter int                        DATA_WIDTH     = 8,
  parameter int                        ADDR_WIDTH     = 12,
  parameter int                        CPU_ADDR_WIDTH = 16,
  parameter logic [CPU_ADDR_WIDTH-1:0] BASE_ADDR      = 16'h0000
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [CPU_ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  output logic                      rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_err,
  input  logic                      clear_start,
  output logic                      clear_busy,
  output logic                      mem_rd_enable,
  output logic [3:0]                mem_wr_enable,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wr_data,
  input  logic [DATA_WIDTH-1:0]     mem_rd_data
);

  localparam logic [ADDR_WIDTH-1:0] CLR_LAST = '1;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic                    hit;
  logic [ADDR_WIDTH-1:0]   win_off;

  mem_window_decode #(
    .CPU_ADDR_WIDTH (CPU_ADDR_WIDTH),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .BASE_ADDR      (BASE_ADDR)
  ) u_decode (
    .req_addr (req_addr),
    .hit      (hit),
    .mem_off  (win_off)
  );

  // Strobes and the response pulse default low every cycle; rsp data/err and mem_addr hold.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      clr_cnt       <= '0;
      req_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
      clear_busy    <= 1'b0;
      mem_rd_enable <= 1'b0;
      mem_wr_enable <= WE_NONE;
      mem_addr      <= '0;
      mem_wr_data   <= '0;
    end else begin
      rsp_valid     <= 1'b0;
      mem_rd_enable <= 1'b0;
      mem_wr_enable <= WE_NONE;
      mem_wr_data   <= '0;

      case (state)
        IDLE: begin
          // A clear request wins over a request presented in the same cycle.
          if (clear_start) begin
            state         <= CLEAR;
            req_ready     <= 1'b0;
            clear_busy    <= 1'b1;
            clr_cnt       <= '0;
            mem_addr      <= '0;
            mem_wr_enable <= WE_ALL;
          end else if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            if (!hit) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              state     <= RSP;
            end else if (req_we) begin
              mem_addr      <= win_off;
              mem_wr_enable <= WE_ALL;
              mem_wr_data   <= req_wdata;
              rsp_valid     <= 1'b1;
              rsp_err       <= 1'b0;
              rsp_rdata     <= '0;
              state         <= WR;
            end else begin
              mem_addr      <= win_off;
              mem_rd_enable <= 1'b1;
              state         <= RD_ISSUE;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end

        WR: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end

        RD_ISSUE: begin
          state <= RD_WAIT;
        end

        RD_WAIT: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= mem_rd_data;
          state     <= RSP;
        end

        RSP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end

        CLEAR: begin
          if (clr_cnt == CLR_LAST) begin
            clr_cnt    <= '0;
            clear_busy <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end else begin
            clr_cnt       <= clr_cnt + 1'b1;
            mem_addr      <= clr_cnt + 1'b1;
            mem_wr_enable <= WE_ALL;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_requester.sv
// Randomised scoreboard bench for mem_requester: two instances (base 0x0000 and 0x2000),
// each driving its own byte-RAM model, checked against a plain array reference.
module tb_mem_requester;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic [1:0]  req_valid, req_we, clear_start;
  logic [15:0] req_addr [2];
  logic [7:0]  req_wdata [2];
  logic [1:0]  req_ready, rsp_valid, rsp_err, clear_busy, mem_rd_enable;
  logic [7:0]  rsp_rdata [2];
  logic [7:0]  mem_wr_data [2];
  logic [7:0]  mem_rd_data [2];
  logic [3:0]  mem_wr_enable [2];
  logic [11:0] mem_addr [2];

  mem_requester #(.DATA_WIDTH(8), .ADDR_WIDTH(12), .CPU_ADDR_WIDTH(16), .BASE_ADDR(16'h0000)) dut0 (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
    .clear_start(clear_start[0]), .clear_busy(clear_busy[0]),
    .mem_rd_enable(mem_rd_enable[0]), .mem_wr_enable(mem_wr_enable[0]),
    .mem_addr(mem_addr[0]), .mem_wr_data(mem_wr_data[0]), .mem_rd_data(mem_rd_data[0])
  );

  mem_requester #(.DATA_WIDTH(8), .ADDR_WIDTH(12), .CPU_ADDR_WIDTH(16), .BASE_ADDR(16'h2000)) dut1 (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
    .clear_start(clear_start[1]), .clear_busy(clear_busy[1]),
    .mem_rd_enable(mem_rd_enable[1]), .mem_wr_enable(mem_wr_enable[1]),
    .mem_addr(mem_addr[1]), .mem_wr_data(mem_wr_data[1]), .mem_rd_data(mem_rd_data[1])
  );

  // Byte RAMs seen by each instance: write on any enable bit, registered read data.
  logic [7:0] ram0 [4096];
  logic [7:0] ram1 [4096];
  always @(posedge clk) begin
    if (mem_wr_enable[0] != 4'h0) ram0[mem_addr[0]] <= mem_wr_data[0];
    if (mem_rd_enable[0]) mem_rd_data[0] <= ram0[mem_addr[0]];
    if (mem_wr_enable[1] != 4'h0) ram1[mem_addr[1]] <= mem_wr_data[1];
    if (mem_rd_enable[1]) mem_rd_data[1] <= ram1[mem_addr[1]];
  end

  logic [7:0] ref_mem [2][4096];

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int overlap_errs = 0;
  always @(posedge clk)
    overlap_errs <= overlap_errs
                    + ((mem_rd_enable[0] === 1'b1 && mem_wr_enable[0] !== 4'h0) ? 1 : 0)
                    + ((mem_rd_enable[1] === 1'b1 && mem_wr_enable[1] !== 4'h0) ? 1 : 0);

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic logic model_hit(input int d, input logic [15:0] addr, output int off);
    int base;
    base = (d == 0) ? 0 : 'h2000;
    off  = int'(addr) - base;
    return (off >= 0) && (off < 4096);
  endfunction

  function automatic logic [15:0] pickAddr(input int d);
    logic [15:0] base;
    base = (d == 0) ? 16'h0000 : 16'h2000;
    case ($urandom_range(0, 3))
      0:       return base + 16'($urandom_range(0, 15));
      1:       return 16'($urandom);
      2:       return base + 16'h0FFF - 16'($urandom_range(0, 3));
      default: return base - 16'h0001 - 16'($urandom_range(0, 3));
    endcase
  endfunction

  task automatic monitorRsp(input int d);
    exp_t e;
    int   n;
    if (rsp_valid[d] !== 1'b1) return;
    n = (d == 0) ? exp_q0.size() : exp_q1.size();
    if (n == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_rsp dut%0d: got rsp_valid=1 expected none (cycle %0d)", d, cycle);
      return;
    end
    if (d == 0) e = exp_q0.pop_front();
    else        e = exp_q1.pop_front();
    checkOutput($sformatf("dut%0d rsp_rdata", d), 32'(rsp_rdata[d]), 32'(e.rdata));
    checkOutput($sformatf("dut%0d rsp_err", d), 32'(rsp_err[d]), 32'(e.err));
    checkOutput($sformatf("dut%0d rsp_cycle", d), cycle, e.cyc);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      monitorRsp(0);
      monitorRsp(1);
    end
  end

  // Issues one request, checks the RAM port in the cycle after acceptance and queues the response.
  task automatic applyStimulus(input int d, input logic we, input logic [15:0] addr,
                               input logic [7:0] wdata, input bit hold);
    int    waited;
    int    off;
    logic  hit;
    exp_t  e;
    string tag;
    waited       = 0;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_valid[d] = 1'b1;
    while (req_ready[d] !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (req_ready[d] !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL dut%0d ready_timeout: got req_ready=0 expected 1 within 100 cycles", d);
      req_valid[d] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    hit = model_hit(d, addr, off);
    tag = $sformatf("dut%0d %s 0x%04h", d, we ? "wr" : "rd", addr);
    checkOutput({tag, " req_ready"}, 32'(req_ready[d]), 32'(0));
    if (hit) checkOutput({tag, " mem_addr"}, 32'(mem_addr[d]), 32'(off[11:0]));
    checkOutput({tag, " mem_rd_enable"}, 32'(mem_rd_enable[d]), 32'(hit && !we));
    checkOutput({tag, " mem_wr_enable"}, 32'(mem_wr_enable[d]), (hit && we) ? 32'hF : 32'h0);
    if (hit && we) checkOutput({tag, " mem_wr_data"}, 32'(mem_wr_data[d]), 32'(wdata));
    e.err = !hit;
    e.cyc = cycle + ((hit && !we) ? 2 : 0);
    if (!hit || we) e.rdata = 8'h00;
    else            e.rdata = ref_mem[d][off];
    if (hit && we) ref_mem[d][off] = wdata;
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
    if (!hold) req_valid[d] = 1'b0;
  endtask

  task automatic runClear();
    int busy_cnt;
    int wr_errs;
    int waited;
    busy_cnt = 0;
    wr_errs  = 0;
    waited   = 0;
    while (req_ready[0] !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("clear ready_before", 32'(req_ready[0]), 32'(1));
    clear_start[0] = 1'b1;
    req_valid[0]   = 1'b1;
    req_we[0]      = 1'b1;
    req_addr[0]    = 16'h0007;
    req_wdata[0]   = 8'h77;
    @(posedge clk);
    #1;
    clear_start[0] = 1'b0;
    req_valid[0]   = 1'b0;
    checkOutput("clear req_ready", 32'(req_ready[0]), 32'(0));
    checkOutput("clear busy_first", 32'(clear_busy[0]), 32'(1));
    while (clear_busy[0] === 1'b1 && busy_cnt < 5000) begin
      if (mem_wr_enable[0] !== 4'hF || mem_wr_data[0] !== 8'h00 || mem_addr[0] !== busy_cnt[11:0])
        wr_errs++;
      busy_cnt++;
      @(posedge clk);
      #1;
    end
    checkOutput("clear busy_cycles", busy_cnt, 4096);
    checkOutput("clear write_errors", wr_errs, 0);
    checkOutput("clear wr_enable_after", 32'(mem_wr_enable[0]), 32'(0));
    checkOutput("clear ready_after", 32'(req_ready[0]), 32'(1));
    for (int i = 0; i < 4096; i++) ref_mem[0][i] = 8'h00;
  endtask

  task automatic resetMidRead();
    applyStimulus(0, 1'b0, 16'h0123, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    checkOutput("midreset req_ready", 32'(req_ready[0]), 32'(0));
    checkOutput("midreset rsp_valid", 32'(rsp_valid[0]), 32'(0));
    checkOutput("midreset rsp_rdata", 32'(rsp_rdata[0]), 32'(0));
    checkOutput("midreset rsp_err", 32'(rsp_err[0]), 32'(0));
    checkOutput("midreset clear_busy", 32'(clear_busy[0]), 32'(0));
    checkOutput("midreset mem_rd_enable", 32'(mem_rd_enable[0]), 32'(0));
    checkOutput("midreset mem_wr_enable", 32'(mem_wr_enable[0]), 32'(0));
    checkOutput("midreset mem_addr", 32'(mem_addr[0]), 32'(0));
    checkOutput("midreset mem_wr_data", 32'(mem_wr_data[0]), 32'(0));
    exp_q0.delete();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    checkOutput("midreset ready_at_release", 32'(req_ready[0]), 32'(0));
    @(posedge clk);
    #1;
    checkOutput("midreset ready_after_edge", 32'(req_ready[0]), 32'(1));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 500000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] v;
    logic       we;
    bit         hold;
    resetn      = 1'b0;
    req_valid   = 2'b00;
    req_we      = 2'b00;
    clear_start = 2'b00;
    for (int d = 0; d < 2; d++) begin
      req_addr[d]  = 16'h0000;
      req_wdata[d] = 8'h00;
    end
    for (int i = 0; i < 4096; i++) begin
      v = 8'($urandom);
      ram0[i] <= v;
      ref_mem[0][i] = v;
      v = 8'($urandom);
      ram1[i] <= v;
      ref_mem[1][i] = v;
    end

    #12;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("reset dut%0d req_ready", d), 32'(req_ready[d]), 32'(0));
      checkOutput($sformatf("reset dut%0d rsp_valid", d), 32'(rsp_valid[d]), 32'(0));
      checkOutput($sformatf("reset dut%0d clear_busy", d), 32'(clear_busy[d]), 32'(0));
      checkOutput($sformatf("reset dut%0d mem_wr_enable", d), 32'(mem_wr_enable[d]), 32'(0));
      checkOutput($sformatf("reset dut%0d mem_rd_enable", d), 32'(mem_rd_enable[d]), 32'(0));
    end
    @(negedge clk);
    resetn = 1'b1;
    checkOutput("release ready_before_edge", 32'(req_ready[0]), 32'(0));
    @(posedge clk);
    #1;
    checkOutput("release dut0 ready", 32'(req_ready[0]), 32'(1));
    checkOutput("release dut1 ready", 32'(req_ready[1]), 32'(1));

    $display("[TB] directed write/read and window edges");
    applyStimulus(0, 1'b1, 16'h0123, 8'hA5, 1'b0);
    applyStimulus(0, 1'b0, 16'h0123, 8'h00, 1'b0);
    applyStimulus(0, 1'b0, 16'h1000, 8'h00, 1'b0);
    applyStimulus(1, 1'b0, 16'h1FFF, 8'h00, 1'b0);
    applyStimulus(1, 1'b1, 16'h2FFF, 8'h5A, 1'b0);
    applyStimulus(1, 1'b1, 16'h2000, 8'hC3, 1'b0);
    applyStimulus(1, 1'b0, 16'h2FFF, 8'h00, 1'b0);
    applyStimulus(1, 1'b0, 16'h2000, 8'h00, 1'b0);
    applyStimulus(1, 1'b1, 16'h3000, 8'h11, 1'b0);

    $display("[TB] randomised traffic");
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 60; i++) begin
        we   = 1'($urandom_range(0, 1));
        hold = (i != 59) && ($urandom_range(0, 1) == 1);
        applyStimulus(d, we, pickAddr(d), 8'($urandom), hold);
      end
    end

    $display("[TB] back-to-back stream with req_valid held");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1'b1, 16'(16'h0040 + i), 8'(i * 17 + 3), 1'b1);
      applyStimulus(0, 1'b0, 16'(16'h0040 + i), 8'h00, i != 7);
    end

    $display("[TB] bulk clear");
    applyStimulus(0, 1'b1, 16'h0005, 8'h3C, 1'b0);
    applyStimulus(0, 1'b0, 16'h0005, 8'h00, 1'b0);
    repeat (4) @(negedge clk);
    runClear();
    applyStimulus(0, 1'b0, 16'h0005, 8'h00, 1'b0);
    applyStimulus(0, 1'b0, 16'h0FFF, 8'h00, 1'b0);
    applyStimulus(0, 1'b0, 16'h0000, 8'h00, 1'b0);

    $display("[TB] reset during read wait");
    repeat (4) @(negedge clk);
    resetMidRead();
    applyStimulus(0, 1'b0, 16'h0123, 8'h00, 1'b0);

    repeat (10) @(negedge clk);
    checkOutput("pending dut0", exp_q0.size(), 0);
    checkOutput("pending dut1", exp_q1.size(), 0);
    checkOutput("strobe_overlap", overlap_errs, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
